fsm_rd_collector: RTL and testbench

Downstream consumer of the read-control FSM's registered strobes `rd` (per-beat read) and `ds` (done strobe).
- Samples the memory read bus on every cycle `rd` is high.
- Packs the beats into one wide word and, on `ds`, commits the word plus an error flag into a small output buffer.
- Presents the buffer as a valid/ready stream.
- Drives `go_ok` back so the requester only raises `go` when a completed transaction has somewhere to land.

---
 rtl/fsm_rd_collector_pkg.sv | 22 ++
 rtl/fsm_rd_collector_if.sv | 28 ++
 rtl/fsm_rd_collector_sync_fifo_ff.sv | 80 ++++++++
 rtl/fsm_rd_collector.sv | 141 ++++++++++++++
 tb/tb_fsm_rd_collector.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fsm_rd_collector_pkg.sv
// Shared types and helpers for the read-data collector that sits behind the read-control FSM.
package fsm_rd_collector_pkg;

    typedef enum logic [0:0] {
        C_IDLE    = 1'b0,
        C_COLLECT = 1'b1
    } coll_state_e;

    localparam int DROP_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        logic [DROP_CNT_W-1:0] r;
        if (v == {DROP_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/fsm_rd_collector_if.sv
// Strobe/data inputs from the read FSM and the output stream/status of the collector.
interface fsm_rd_collector_if
    import fsm_rd_collector_pkg::*;
#(
    parameter int DW    = 8,
    parameter int BEATS = 4
) ();
    logic                  rd;
    logic                  ds;
    logic [DW-1:0]         rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW*BEATS-1:0]   out_data;
    logic                  out_err;
    logic                  go_ok;
    logic                  busy;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport slave (
        input  rd, ds, rdata, out_ready,
        output out_valid, out_data, out_err, go_ok, busy, drop_cnt
    );

    modport master (
        output rd, ds, rdata, out_ready,
        input  out_valid, out_data, out_err, go_ok, busy, drop_cnt
    );
endinterface

// File: rtl/fsm_rd_collector_sync_fifo_ff.sv
// Register-based circular FIFO; pointers wrap at DEPTH so non-power-of-two depths work.
module sync_fifo_ff #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [NW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [NW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(DEPTH - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = p + {{(PW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Pop/push qualification and next pointer/occupancy; a push into a full FIFO is allowed only alongside a pop.
    always_comb begin
        do_pop_s  = pop_i && (count_q != {NW{1'b0}});
        do_push_s = push_i && ((count_q < NW'(DEPTH)) || do_pop_s);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + {{(NW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(NW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Storage, pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {NW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == NW'(DEPTH));
    assign empty_o = (count_q == {NW{1'b0}});
    assign count_o = count_q;
endmodule

// File: rtl/fsm_rd_collector.sv
// Packs read beats strobed by the read FSM into one word per transaction and streams {err, word} out.
module fsm_rd_collector
    import fsm_rd_collector_pkg::*;
#(
    parameter int DW    = 8,
    parameter int BEATS = 4,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fsm_rd_collector_if.slave  bus
);
    localparam int CW = $clog2(BEATS + 1);
    localparam int WW = DW * BEATS;
    localparam int NW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          err;
        logic [WW-1:0] word;
    } coll_entry_t;

    coll_state_e           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_fin_s;
    logic [WW-1:0]         asm_q, asm_d, word_fin_s;
    logic                  ovr_q, ovr_d, ovr_fin_s;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  commit_s, push_s, pop_s;
    logic                  full_s, empty_s;
    logic [NW-1:0]         count_s;
    coll_entry_t           entry_s, head_s;

    // Word, beat count and overrun as they stand including this cycle's beat, used for both update and commit.
    always_comb begin
        word_fin_s = asm_q;
        cnt_fin_s  = cnt_q;
        ovr_fin_s  = ovr_q;
        if (bus.rd && (cnt_q < CW'(BEATS))) begin
            word_fin_s[cnt_q*DW +: DW] = bus.rdata;
            cnt_fin_s = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            ovr_fin_s = ovr_q | bus.rd;
        end
        entry_s.err  = ovr_fin_s || (cnt_fin_s != CW'(BEATS));
        entry_s.word = word_fin_s;
    end

    // Collection FSM: a done strobe always commits and clears the assembly state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        ovr_d    = ovr_q;
        commit_s = 1'b0;
        case (state_q)
            C_IDLE: begin
                if (bus.ds) begin
                    commit_s = 1'b1;
                    cnt_d    = {CW{1'b0}};
                    asm_d    = {WW{1'b0}};
                    ovr_d    = 1'b0;
                end else if (bus.rd) begin
                    asm_d   = word_fin_s;
                    cnt_d   = cnt_fin_s;
                    ovr_d   = ovr_fin_s;
                    state_d = C_COLLECT;
                end else begin
                    state_d = C_IDLE;
                end
            end
            C_COLLECT: begin
                if (bus.ds) begin
                    commit_s = 1'b1;
                    cnt_d    = {CW{1'b0}};
                    asm_d    = {WW{1'b0}};
                    ovr_d    = 1'b0;
                    state_d  = C_IDLE;
                end else begin
                    asm_d = word_fin_s;
                    cnt_d = cnt_fin_s;
                    ovr_d = ovr_fin_s;
                end
            end
            default: begin
                cnt_d   = {CW{1'b0}};
                asm_d   = {WW{1'b0}};
                ovr_d   = 1'b0;
                state_d = C_IDLE;
            end
        endcase
    end

    // A commit lands if a slot is free after this cycle's pop; otherwise it is counted as dropped.
    always_comb begin
        pop_s  = !empty_s && bus.out_ready;
        push_s = commit_s && (!full_s || pop_s);
        if (commit_s && !push_s) begin
            drop_d = sat_inc(drop_q);
        end else begin
            drop_d = drop_q;
        end
    end

    // Collector state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
            cnt_q   <= {CW{1'b0}};
            asm_q   <= {WW{1'b0}};
            ovr_q   <= 1'b0;
            drop_q  <= {DROP_CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            ovr_q   <= ovr_d;
            drop_q  <= drop_d;
        end
    end

    sync_fifo_ff #(
        .DEPTH (DEPTH),
        .WIDTH (WW + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i (entry_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    assign bus.out_valid = !empty_s;
    assign bus.out_data  = head_s.word;
    assign bus.out_err   = head_s.err;
    assign bus.go_ok     = (state_q == C_IDLE) && (count_s < NW'(DEPTH));
    assign bus.busy      = (state_q == C_COLLECT);
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_fsm_rd_collector.sv
// Directed vector bench for fsm_rd_collector (DW=8, BEATS=4, DEPTH=2).
module tb_fsm_rd_collector;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;

    typedef struct {
        logic        rd;
        logic        ds;
        logic [7:0]  rdata;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
        logic        eg;
        logic        eb;
        logic [7:0]  edrop;
    } vec_t;

    vec_t vq[$];

    fsm_rd_collector_if #(.DW(8), .BEATS(4)) bus ();

    fsm_rd_collector #(.DW(8), .BEATS(4), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rd, input logic ds, input logic [7:0] rdata,
                                input logic rdy, input logic ev, input logic [31:0] ed,
                                input logic ee, input logic eg, input logic eb,
                                input logic [7:0] edrop);
        vec_t v;
        v.rd = rd; v.ds = ds; v.rdata = rdata; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.ee = ee; v.eg = eg; v.eb = eb; v.edrop = edrop;
        return v;
    endfunction

    task automatic check(input string name, input logic ev, input logic [31:0] ed,
                         input logic ee, input logic eg, input logic eb,
                         input logic [7:0] edrop, input logic chk_data);
        logic bad;
        bad = (bus.out_valid !== ev) || (bus.go_ok !== eg) || (bus.busy !== eb) ||
              (bus.drop_cnt !== edrop);
        if (chk_data && ((bus.out_data !== ed) || (bus.out_err !== ee))) bad = 1'b1;
        n_vec++;
        if (bad) begin
            n_miss++;
            $display("FAIL %s: got valid=%b data=%h err=%b go_ok=%b busy=%b drop=%0d; want valid=%b data=%h err=%b go_ok=%b busy=%b drop=%0d",
                     name, bus.out_valid, bus.out_data, bus.out_err, bus.go_ok, bus.busy,
                     bus.drop_cnt, ev, ed, ee, eg, eb, edrop);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        bus.rd        = v.rd;
        bus.ds        = v.ds;
        bus.rdata     = v.rdata;
        bus.out_ready = v.rdy;
        @(posedge clk);
        #1;
        check(name, v.ev, v.ed, v.ee, v.eg, v.eb, v.edrop, v.ev);
    endtask

    initial begin
        // nominal, held then popped
        vq.push_back(mk(1'b1,1'b0,8'h11,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h22,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h33,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b1,8'h44,1'b0, 1'b1,32'h44332211,1'b0,1'b1,1'b0,8'd0));
        vq.push_back(mk(1'b0,1'b0,8'h00,1'b0, 1'b1,32'h44332211,1'b0,1'b1,1'b0,8'd0));
        vq.push_back(mk(1'b0,1'b0,8'h00,1'b1, 1'b0,32'h0,1'b0,1'b1,1'b0,8'd0));
        // short transaction
        vq.push_back(mk(1'b1,1'b0,8'hAA,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'hBB,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b0,1'b1,8'h00,1'b0, 1'b1,32'h0000BBAA,1'b1,1'b1,1'b0,8'd0));
        vq.push_back(mk(1'b0,1'b0,8'h00,1'b1, 1'b0,32'h0,1'b0,1'b1,1'b0,8'd0));
        // overrun, then a clean nominal
        vq.push_back(mk(1'b1,1'b0,8'h01,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h02,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h03,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h04,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h05,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b1,8'h06,1'b0, 1'b1,32'h04030201,1'b1,1'b1,1'b0,8'd0));
        vq.push_back(mk(1'b0,1'b0,8'h00,1'b1, 1'b0,32'h0,1'b0,1'b1,1'b0,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h11,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h22,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h33,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b1,8'h44,1'b0, 1'b1,32'h44332211,1'b0,1'b1,1'b0,8'd0));
        vq.push_back(mk(1'b0,1'b0,8'h00,1'b1, 1'b0,32'h0,1'b0,1'b1,1'b0,8'd0));
        // done strobe with no beats
        vq.push_back(mk(1'b0,1'b1,8'h00,1'b0, 1'b1,32'h0,1'b1,1'b1,1'b0,8'd0));
        vq.push_back(mk(1'b0,1'b0,8'h00,1'b1, 1'b0,32'h0,1'b0,1'b1,1'b0,8'd0));
        // backpressure: two buffered, third dropped, then drained in order
        vq.push_back(mk(1'b1,1'b0,8'h01,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h02,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h03,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b1,8'h04,1'b0, 1'b1,32'h04030201,1'b0,1'b1,1'b0,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h05,1'b0, 1'b1,32'h04030201,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h06,1'b0, 1'b1,32'h04030201,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h07,1'b0, 1'b1,32'h04030201,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b1,8'h08,1'b0, 1'b1,32'h04030201,1'b0,1'b0,1'b0,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h09,1'b0, 1'b1,32'h04030201,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h0A,1'b0, 1'b1,32'h04030201,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b0,8'h0B,1'b0, 1'b1,32'h04030201,1'b0,1'b0,1'b1,8'd0));
        vq.push_back(mk(1'b1,1'b1,8'h0C,1'b0, 1'b1,32'h04030201,1'b0,1'b0,1'b0,8'd1));
        vq.push_back(mk(1'b0,1'b0,8'h00,1'b1, 1'b1,32'h08070605,1'b0,1'b1,1'b0,8'd1));
        vq.push_back(mk(1'b0,1'b0,8'h00,1'b1, 1'b0,32'h0,1'b0,1'b1,1'b0,8'd1));
        // full buffer: commit coincides with a pop
        vq.push_back(mk(1'b1,1'b0,8'h10,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd1));
        vq.push_back(mk(1'b1,1'b0,8'h11,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd1));
        vq.push_back(mk(1'b1,1'b0,8'h12,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd1));
        vq.push_back(mk(1'b1,1'b1,8'h13,1'b0, 1'b1,32'h13121110,1'b0,1'b1,1'b0,8'd1));
        vq.push_back(mk(1'b1,1'b0,8'h20,1'b0, 1'b1,32'h13121110,1'b0,1'b0,1'b1,8'd1));
        vq.push_back(mk(1'b1,1'b0,8'h21,1'b0, 1'b1,32'h13121110,1'b0,1'b0,1'b1,8'd1));
        vq.push_back(mk(1'b1,1'b0,8'h22,1'b0, 1'b1,32'h13121110,1'b0,1'b0,1'b1,8'd1));
        vq.push_back(mk(1'b1,1'b1,8'h23,1'b0, 1'b1,32'h13121110,1'b0,1'b0,1'b0,8'd1));
        vq.push_back(mk(1'b1,1'b0,8'h30,1'b0, 1'b1,32'h13121110,1'b0,1'b0,1'b1,8'd1));
        vq.push_back(mk(1'b1,1'b0,8'h31,1'b0, 1'b1,32'h13121110,1'b0,1'b0,1'b1,8'd1));
        vq.push_back(mk(1'b1,1'b0,8'h32,1'b0, 1'b1,32'h13121110,1'b0,1'b0,1'b1,8'd1));
        vq.push_back(mk(1'b1,1'b1,8'h33,1'b1, 1'b1,32'h23222120,1'b0,1'b0,1'b0,8'd1));
        vq.push_back(mk(1'b0,1'b0,8'h00,1'b1, 1'b1,32'h33323130,1'b0,1'b1,1'b0,8'd1));
        vq.push_back(mk(1'b0,1'b0,8'h00,1'b1, 1'b0,32'h0,1'b0,1'b1,1'b0,8'd1));

        rst_n         = 1'b0;
        bus.rd        = 1'b0;
        bus.ds        = 1'b0;
        bus.rdata     = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], $sformatf("vec%0d", i));
        end

        // Reset mid-collect with an entry already buffered and a nonzero drop count.
        apply(mk(1'b1,1'b1,8'h5A,1'b0, 1'b1,32'h0000005A,1'b1,1'b1,1'b0,8'd1), "single_beat");
        apply(mk(1'b1,1'b0,8'h01,1'b0, 1'b1,32'h0000005A,1'b1,1'b0,1'b1,8'd1), "pre_rst_beat0");
        apply(mk(1'b1,1'b0,8'h02,1'b0, 1'b1,32'h0000005A,1'b1,1'b0,1'b1,8'd1), "pre_rst_beat1");
        bus.rd = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_async", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
        @(posedge clk);
        #1;
        check("rst_held", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
        rst_n = 1'b1;
        apply(mk(1'b1,1'b0,8'h55,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0), "post_rst_b0");
        apply(mk(1'b1,1'b0,8'h66,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0), "post_rst_b1");
        apply(mk(1'b1,1'b0,8'h77,1'b0, 1'b0,32'h0,1'b0,1'b0,1'b1,8'd0), "post_rst_b2");
        apply(mk(1'b1,1'b1,8'h88,1'b0, 1'b1,32'h88776655,1'b0,1'b1,1'b0,8'd0), "post_rst_commit");
        apply(mk(1'b0,1'b0,8'h00,1'b1, 1'b0,32'h0,1'b0,1'b1,1'b0,8'd0), "post_rst_pop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
